// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write-port arbiter.
// The stall counter is only built when FIFO_ARB_STATS_EN is defined.
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StGrant
  } arb_state_e;

  localparam int unsigned StallCntW = 16;

  // The counter must be able to hold max_burst itself.
  function automatic int unsigned burst_cnt_w(input int unsigned max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: returns the first set request
// found by searching upward from last_i + 1, wrapping around.
module rr_pick #(
  parameter int unsigned NumReq = 4,
  parameter int unsigned IdxW   = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   last_i,
  output logic              found_o,
  output logic [IdxW-1:0]   idx_o
);

  int unsigned cand;

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    cand    = 0;
    // Offset NumReq wraps back to last_i, so it has the lowest priority.
    for (int unsigned off = 1; off <= NumReq; off++) begin
      cand = (32'(last_i) + off) % NumReq;
      if (!found_o && req_i[IdxW'(cand)]) begin
        found_o = 1'b1;
        idx_o   = IdxW'(cand);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO write port, with bounded bursts.
// Define FIFO_ARB_STATS_EN to add the saturating stall_cnt_o output.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NumReq   = 4,
  parameter int unsigned Width    = 8,
  parameter int unsigned MaxBurst = 4
) (
  input  logic                       clk_wr_i,
  input  logic                       rst_wr_ni,
  input  logic [NumReq-1:0]          req_valid_i,
  input  logic [NumReq*Width-1:0]    req_data_i,
  input  logic [NumReq-1:0]          req_last_i,
  output logic [NumReq-1:0]          req_ready_o,
  input  logic                       fifo_full_i,
  output logic                       fifo_wr_o,
  output logic [Width-1:0]           fifo_data_o,
  output logic [$clog2(NumReq)-1:0]  grant_id_o,
  output logic                       busy_o
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [StallCntW-1:0]       stall_cnt_o
`endif
);

  localparam int unsigned IdxW = $clog2(NumReq);
  localparam int unsigned CntW = burst_cnt_w(MaxBurst);
  localparam logic [CntW-1:0] BurstMax = CntW'(MaxBurst);

  arb_state_e      state_q, state_d;
  logic [IdxW-1:0] grant_q, grant_d;
  logic [IdxW-1:0] last_q, last_d;
  logic [CntW-1:0] burst_q, burst_d, burst_inc;

  logic             pick_found;
  logic [IdxW-1:0]  pick_idx;
  logic             g_valid, g_last, xfer;
  logic [Width-1:0] g_data;

  rr_pick #(
    .NumReq (NumReq),
    .IdxW   (IdxW)
  ) u_rr_pick (
    .req_i   (req_valid_i),
    .last_i  (last_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (grant_q == IdxW'(i)) begin
        g_valid = req_valid_i[i];
        g_last  = req_last_i[i];
        g_data  = req_data_i[i*Width +: Width];
      end
    end
  end

  assign xfer      = (state_q == StGrant) && g_valid && !fifo_full_i;
  assign burst_inc = burst_q + CntW'(1);

  always_comb begin
    fifo_wr_o   = xfer;
    fifo_data_o = xfer ? g_data : '0;
    for (int i = 0; i < NumReq; i++) begin
      req_ready_o[i] = xfer && (grant_q == IdxW'(i));
    end
  end

  assign grant_id_o = grant_q;
  assign busy_o     = (state_q == StGrant);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    burst_d = burst_q;
    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          state_d = StGrant;
          grant_d = pick_idx;
          burst_d = '0;
        end
      end
      StGrant: begin
        if (!g_valid) begin
          // Requester abandoned its burst.
          state_d = StIdle;
          last_d  = grant_q;
        end else if (xfer) begin
          burst_d = burst_inc;
          if (g_last || (burst_inc == BurstMax)) begin
            state_d = StIdle;
            last_d  = grant_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_wr_i or negedge rst_wr_ni) begin
    if (!rst_wr_ni) begin
      state_q <= StIdle;
      grant_q <= '0;
      last_q  <= IdxW'(NumReq - 1);
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      burst_q <= burst_d;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [StallCntW-1:0] stall_q;

  always_ff @(posedge clk_wr_i or negedge rst_wr_ni) begin
    if (!rst_wr_ni) begin
      stall_q <= '0;
    end else if ((state_q == StGrant) && g_valid && fifo_full_i && (stall_q != '1)) begin
      stall_q <= stall_q + StallCntW'(1);
    end
  end

  assign stall_cnt_o = stall_q;
`endif

endmodule
